blink_pattern_generator: RTL and testbench

- Synthetic camera-line source for bring-up and regression of the blinking-point frequency measurement path.
- Emits an 8-bit pixel stream with its own pixel clock: dark pixels, then colour pixels, with three point windows whose brightness square-waves at a selectable per-point frequency.
- Also drives the start/stop control pair that the measurement manager expects.
- Sits in place of the sensor front-end on test builds; its outputs connect directly to the manager's data, pixel_clock, start and stop inputs.

---
 rtl/blink_pattern_generator.sv | 219 +++++++++++++++++++++
 tb/tb_blink_pattern_generator.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/blink_pattern_generator.sv
// blink_pattern_generator
//   Synthetic camera-line source for bring-up of the blinking-point frequency
//   measurement path. Produces a pixel stream (dark pixels, then colour pixels
//   containing three blinking point windows) together with the start/stop pair
//   expected by the measurement manager.
//
// Ports
//   i_clock         system clock
//   i_reset         synchronous, active-high reset
//   i_go            pulse; begins a run when idle
//   i_abort         pulse; ends a run early (START/RUN only)
//   i_duration      run length in clock cycles, sampled on accepted go (0 -> 1)
//   i_freq_select   bit n picks POINTn_FREQUENCY1 for point n, sampled on go
//   o_pixel_clock   pixel clock, period PIXEL_DIVIDER cycles
//   o_data          pixel value
//   o_start         high exactly while in START
//   o_stop          high exactly while in STOP
//   o_busy          high in every state except IDLE
//   o_line_count    completed lines in the current run (wraps)
//
// state   | meaning
// S_IDLE  | waiting for go; pixel path parked
// S_START | start pulse, pixel stream and blink phases running
// S_RUN   | pixel stream running for the latched duration
// S_STOP  | stop level held, pixel path parked, then back to idle
module blink_pattern_generator #(
  parameter int CLOCK_FREQUENCY        = 100000000,
  parameter int PIXEL_DIVIDER          = 4,
  parameter int TAP_DARK_PIXELS_COUNT  = 16,
  parameter int TAP_COLOR_PIXELS_COUNT = 1024,
  parameter int PIXEL0_INDEX           = 2,
  parameter int PIXEL1_INDEX           = 256,
  parameter int PIXEL2_INDEX           = 768,
  parameter int POINT_WIDTH_PIXEL      = 32,
  parameter int POINT0_FREQUENCY0      = 5000,
  parameter int POINT0_FREQUENCY1      = 10000,
  parameter int POINT1_FREQUENCY0      = 15000,
  parameter int POINT1_FREQUENCY1      = 20000,
  parameter int POINT2_FREQUENCY0      = 25000,
  parameter int POINT2_FREQUENCY1      = 30000,
  parameter int ON_LEVEL               = 200,
  parameter int OFF_LEVEL              = 20,
  parameter int BACKGROUND_LEVEL       = 10,
  parameter int DARK_LEVEL             = 0,
  parameter int START_PULSE_CYCLES     = 4,
  parameter int STOP_HOLD_CYCLES       = 64
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_go,
  input  logic        i_abort,
  input  logic [31:0] i_duration,
  input  logic [2:0]  i_freq_select,
  output logic        o_pixel_clock,
  output logic [7:0]  o_data,
  output logic        o_start,
  output logic        o_stop,
  output logic        o_busy,
  output logic [15:0] o_line_count
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_STOP} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(PIXEL_DIVIDER - 1);
  localparam logic [15:0] DIV_HALF  = 16'(PIXEL_DIVIDER / 2);
  localparam logic [15:0] LINE_LAST = 16'(TAP_DARK_PIXELS_COUNT + TAP_COLOR_PIXELS_COUNT);

  // Half-periods in clock cycles for both frequency choices of each point.
  localparam logic [31:0] HALF0 [3] = '{
    32'(CLOCK_FREQUENCY / (2 * POINT0_FREQUENCY0)),
    32'(CLOCK_FREQUENCY / (2 * POINT1_FREQUENCY0)),
    32'(CLOCK_FREQUENCY / (2 * POINT2_FREQUENCY0))};
  localparam logic [31:0] HALF1 [3] = '{
    32'(CLOCK_FREQUENCY / (2 * POINT0_FREQUENCY1)),
    32'(CLOCK_FREQUENCY / (2 * POINT1_FREQUENCY1)),
    32'(CLOCK_FREQUENCY / (2 * POINT2_FREQUENCY1))};

  state_t      r_state, w_state_nxt;
  logic [31:0] r_tmr, w_tmr_nxt;
  logic [31:0] r_dur;
  logic [2:0]  r_fsel;
  logic [15:0] r_div;
  logic [15:0] r_idx, w_idx_nxt;
  logic [15:0] r_line;
  logic [7:0]  r_data, w_level;
  logic [31:0] r_cnt [3];
  logic [31:0] w_cnt_nxt [3];
  logic [2:0]  r_phase, w_phase_nxt;
  logic        w_running, w_stay_running;

  function automatic logic in_window(input int idx, input int offset);
    int lo;
    lo = TAP_DARK_PIXELS_COUNT + offset;
    return (idx >= lo) && (idx < lo + POINT_WIDTH_PIXEL);
  endfunction

  // Window priority: point0 > point1 > point2.
  function automatic logic [7:0] pixel_level(input logic [15:0] idx, input logic [2:0] ph);
    int i;
    i = int'(idx);
    if (i < TAP_DARK_PIXELS_COUNT)     return 8'(DARK_LEVEL);
    else if (in_window(i, PIXEL0_INDEX)) return ph[0] ? 8'(ON_LEVEL) : 8'(OFF_LEVEL);
    else if (in_window(i, PIXEL1_INDEX)) return ph[1] ? 8'(ON_LEVEL) : 8'(OFF_LEVEL);
    else if (in_window(i, PIXEL2_INDEX)) return ph[2] ? 8'(ON_LEVEL) : 8'(OFF_LEVEL);
    else                                 return 8'(BACKGROUND_LEVEL);
  endfunction

  assign w_running = (r_state == S_START) || (r_state == S_RUN);
  assign w_stay_running = w_running && ((w_state_nxt == S_START) || (w_state_nxt == S_RUN));

  // Sequencing: one shared down-counter times START, RUN and STOP.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      S_IDLE: begin
        if (i_go) begin
          w_state_nxt = S_START;
          w_tmr_nxt   = 32'(START_PULSE_CYCLES - 1);
        end
      end
      S_START: begin
        if (i_abort) begin
          w_state_nxt = S_STOP;
          w_tmr_nxt   = 32'(STOP_HOLD_CYCLES - 1);
        end else if (r_tmr == 32'd0) begin
          w_state_nxt = S_RUN;
          w_tmr_nxt   = r_dur - 32'd1;
        end else begin
          w_tmr_nxt = r_tmr - 32'd1;
        end
      end
      S_RUN: begin
        if (i_abort || (r_tmr == 32'd0)) begin
          w_state_nxt = S_STOP;
          w_tmr_nxt   = 32'(STOP_HOLD_CYCLES - 1);
        end else begin
          w_tmr_nxt = r_tmr - 32'd1;
        end
      end
      S_STOP: begin
        if (r_tmr == 32'd0) w_state_nxt = S_IDLE;
        else                w_tmr_nxt   = r_tmr - 32'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Blink phases and the value of the next pixel. The new pixel is coloured
  // with the phase that takes effect on the same edge.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      w_cnt_nxt[n]   = r_cnt[n];
      w_phase_nxt[n] = r_phase[n];
      if (w_running) begin
        if (r_cnt[n] == (r_fsel[n] ? HALF1[n] : HALF0[n]) - 32'd1) begin
          w_cnt_nxt[n]   = 32'd0;
          w_phase_nxt[n] = ~r_phase[n];
        end else begin
          w_cnt_nxt[n] = r_cnt[n] + 32'd1;
        end
      end
    end
    w_idx_nxt = (r_idx == LINE_LAST) ? 16'd0 : r_idx + 16'd1;
    w_level   = pixel_level(w_idx_nxt, w_phase_nxt);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_dur   <= '0;
      r_fsel  <= '0;
      r_div   <= '0;
      r_idx   <= '0;
      r_line  <= '0;
      r_data  <= '0;
      r_cnt   <= '{default: '0};
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      if ((r_state == S_IDLE) && i_go) begin
        r_dur   <= (i_duration == 32'd0) ? 32'd1 : i_duration;
        r_fsel  <= i_freq_select;
        r_div   <= '0;
        r_idx   <= '0;
        r_line  <= '0;
        r_data  <= 8'(DARK_LEVEL);
        r_cnt   <= '{default: '0};
        r_phase <= 3'b111;
      end else if (w_stay_running) begin
        r_cnt   <= w_cnt_nxt;
        r_phase <= w_phase_nxt;
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_idx  <= w_idx_nxt;
          r_data <= w_level;
          if (r_idx == LINE_LAST) r_line <= r_line + 16'd1;
        end else begin
          r_div <= r_div + 16'd1;
        end
      end else begin
        // Leaving the run or parked: pixel path held; line count kept.
        r_div  <= '0;
        r_idx  <= '0;
        r_data <= 8'(DARK_LEVEL);
      end
    end
  end

  assign o_pixel_clock = (r_div >= DIV_HALF);
  assign o_data        = r_data;
  assign o_start       = (r_state == S_START);
  assign o_stop        = (r_state == S_STOP);
  assign o_busy        = (r_state != S_IDLE);
  assign o_line_count  = r_line;

endmodule

// File: tb/tb_blink_pattern_generator.sv
module tb_blink_pattern_generator;

  logic        clock = 1'b0;
  logic        reset, go, abort;
  logic [31:0] duration;
  logic [2:0]  freq_select;
  logic        pixel_clock, start, stop, busy;
  logic [7:0]  data;
  logic [15:0] line_count;

  int n_assert = 0;
  int n_fail   = 0;

  localparam int LINE_PIX = 1041;
  localparam int HOLD     = 64;

  blink_pattern_generator dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_go          (go),
    .i_abort       (abort),
    .i_duration    (duration),
    .i_freq_select (freq_select),
    .o_pixel_clock (pixel_clock),
    .o_data        (data),
    .o_start       (start),
    .o_stop        (stop),
    .o_busy        (busy),
    .o_line_count  (line_count)
  );

  always #5 clock = ~clock;

  function automatic int half_of(input int n, input logic sel);
    int f0 [3] = '{5000, 15000, 25000};
    int f1 [3] = '{10000, 20000, 30000};
    return 100000000 / (2 * (sel ? f1[n] : f0[n]));
  endfunction

  // Expected pixel value t cycles after the accepted go: pixel p = t/4 was
  // loaded at cycle 4p, when each point had completed (4p / half) half-periods.
  function automatic int model_level(input int t, input logic [2:0] fs);
    int p, idx, h;
    int base [3] = '{16 + 2, 16 + 256, 16 + 768};
    p   = t / 4;
    idx = p % LINE_PIX;
    if (idx < 16) return 0;
    for (int n = 0; n < 3; n++) begin
      if (idx >= base[n] && idx < base[n] + 32) begin
        h = half_of(n, fs[n]);
        return (((4 * p) / h) % 2 == 0) ? 200 : 20;
      end
    end
    return 10;
  endfunction

  task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  // One run: go at t=0, optional abort / second go / reset at given edges.
  task automatic run(input string name, input int dur_raw, input logic [2:0] fs,
                     input int abort_t, input int go2_t, input int reset_t);
    int de, s_edge, held_line, ncyc;
    int e_start, e_stop, e_busy, e_pclk, e_data, e_line;
    de     = (dur_raw == 0) ? 1 : dur_raw;
    s_edge = 4 + de;
    if (abort_t >= 1 && abort_t <= s_edge) s_edge = abort_t;
    held_line = (((s_edge - 1) / 4) / LINE_PIX) % 65536;
    ncyc = (reset_t >= 0) ? reset_t + 10 : s_edge + HOLD + 8;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clock);
      go    = (t == 0) || (t == go2_t) ||
              (reset_t < 0 && t > s_edge && t < s_edge + HOLD && $urandom_range(0, 15) == 0);
      abort = (t == abort_t) || (t > s_edge && $urandom_range(0, 7) == 0);
      reset = (t == reset_t);
      if (t == 0) begin
        duration    = dur_raw;
        freq_select = fs;
      end else begin
        duration    = $urandom;
        freq_select = 3'($urandom);
      end
      @(posedge clock);
      #1;
      go = 1'b0; abort = 1'b0; reset = 1'b0;
      if (reset_t >= 0 && t >= reset_t) begin
        e_start = 0; e_stop = 0; e_busy = 0; e_pclk = 0; e_data = 0; e_line = 0;
      end else if (t < s_edge) begin
        e_start = (t < 4) ? 1 : 0;
        e_stop  = 0;
        e_busy  = 1;
        e_pclk  = ((t % 4) >= 2) ? 1 : 0;
        e_data  = model_level(t, fs);
        e_line  = ((t / 4) / LINE_PIX) % 65536;
      end else if (t < s_edge + HOLD) begin
        e_start = 0; e_stop = 1; e_busy = 1; e_pclk = 0; e_data = 0; e_line = held_line;
      end else begin
        e_start = 0; e_stop = 0; e_busy = 0; e_pclk = 0; e_data = 0; e_line = held_line;
      end
      check({name, ".start"}, t, 32'(start), 32'(e_start));
      check({name, ".stop"},  t, 32'(stop),  32'(e_stop));
      check({name, ".busy"},  t, 32'(busy),  32'(e_busy));
      check({name, ".pclk"},  t, 32'(pixel_clock), 32'(e_pclk));
      check({name, ".data"},  t, 32'(data),  32'(e_data));
      check({name, ".line"},  t, 32'(line_count), 32'(e_line));
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; abort = 1'b0; duration = '0; freq_select = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.start", 0, 32'(start), 32'd0);
    check("rst.stop",  0, 32'(stop),  32'd0);
    check("rst.busy",  0, 32'(busy),  32'd0);
    check("rst.pclk",  0, 32'(pixel_clock), 32'd0);
    check("rst.data",  0, 32'(data),  32'd0);
    check("rst.line",  0, 32'(line_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Nominal run; several full lines with point0 at 5 kHz.
    run("A", 20000, 3'b000, -1, -1, -1);
    // Point0 at 10 kHz; a second go mid-run must be ignored.
    run("B", 18000 + $urandom_range(0, 4000), 3'b001, -1, 3000, -1);
    // Abort 500 cycles into RUN.
    run("C", 20000, 3'($urandom), 504, -1, -1);
    // Zero duration behaves as one cycle.
    run("D", 0, 3'($urandom), -1, -1, -1);
    // Reset mid-run, then a clean restart.
    run("E", 20000, 3'($urandom), -1, -1, 1000 + $urandom_range(0, 500));
    run("F", 6000 + $urandom_range(0, 3000), {1'b1, 2'($urandom)}, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
